pipe_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage MIPS core. It drives the write-enable and flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, and it selects the ID-stage operand bypass sources. It detects load-use and branch-operand hazards, freezes the front of the pipe while a multi-cycle multiply/divide unit (MDU) in EX is busy, and squashes the wrong-path fetch on taken branches and jumps. It also counts stall cycles and latches a sticky error on an MDU timeout.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 21 ++
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 50 +++++
 rtl/pipe_hazard_ctrl.sv | 173 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: FSM states,
// ID-stage bypass source encodings and the register-match rule.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MDU_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } ctrl_state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // $0 is hardwired, so a producer targeting it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] src, input logic src_used,
                                       input logic [4:0] dst, input logic dst_regw);
        return src_used && dst_regw && (dst != 5'd0) && (dst == src);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational hazard terms and ID operand bypass selection for the
// instruction sitting in ID against the EX, MEM and WB producers.
module hazard_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       id_is_branch,
    input  logic [4:0] ex_rd,
    input  logic       ex_regw,
    input  logic       ex_memr,
    input  logic [4:0] mem_rd,
    input  logic       mem_regw,
    input  logic       mem_memr,
    input  logic [4:0] wb_rd,
    input  logic       wb_regw,
    output logic       ld_use,
    output logic       br_ex,
    output logic       br_mem,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    logic ex_hit;
    logic mem_hit;

    assign ex_hit  = reg_match(id_rs, id_use_rs, ex_rd, ex_regw)
                   | reg_match(id_rt, id_use_rt, ex_rd, ex_regw);
    assign mem_hit = reg_match(id_rs, id_use_rs, mem_rd, mem_regw)
                   | reg_match(id_rt, id_use_rt, mem_rd, mem_regw);

    assign ld_use = ex_hit & ex_memr;
    assign br_ex  = id_is_branch & ex_hit & ~ex_memr;
    assign br_mem = id_is_branch & mem_hit & mem_memr;

    // A load in MEM has no data yet, so only an ALU result there can bypass.
    function automatic logic [1:0] pick_src(input logic [4:0] src, input logic used);
        if (reg_match(src, used, mem_rd, mem_regw) && !mem_memr)
            return FWD_MEM;
        else if (reg_match(src, used, wb_rd, wb_regw))
            return FWD_WB;
        return FWD_RF;
    endfunction

    assign fwd_a = pick_src(id_rs, id_use_rs);
    assign fwd_b = pick_src(id_rt, id_use_rt);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline sequencer: stage enables/flushes, branch gating, MDU
// freeze with timeout, saturating stall counter and sticky error flag.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MDU_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_is_branch,
    input  logic             id_pcsel,
    input  logic [4:0]       ex_rd,
    input  logic [4:0]       mem_rd,
    input  logic [4:0]       wb_rd,
    input  logic             ex_regw,
    input  logic             mem_regw,
    input  logic             wb_regw,
    input  logic             ex_memr,
    input  logic             mem_memr,
    input  logic             ex_mdu_start,
    input  logic             mdu_done,
    output logic             pc_wr,
    output logic             ifid_wr,
    output logic             idex_wr,
    output logic             exmem_wr,
    output logic             memwb_wr,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             pcsel_en,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             err
);

    localparam logic [9:0] TO_LAST = 10'(MDU_TIMEOUT - 1);

    ctrl_state_t state, state_nxt;
    logic [9:0]  to_cnt, to_cnt_nxt;
    logic        ld_use, br_ex, br_mem, stall;
    logic [1:0]  hz_fwd_a, hz_fwd_b, hold_fwd_a, hold_fwd_b;
    logic        count_stall;

    hazard_detect u_hazard_detect (
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .id_is_branch (id_is_branch),
        .ex_rd        (ex_rd),
        .ex_regw      (ex_regw),
        .ex_memr      (ex_memr),
        .mem_rd       (mem_rd),
        .mem_regw     (mem_regw),
        .mem_memr     (mem_memr),
        .wb_rd        (wb_rd),
        .wb_regw      (wb_regw),
        .ld_use       (ld_use),
        .br_ex        (br_ex),
        .br_mem       (br_mem),
        .fwd_a        (hz_fwd_a),
        .fwd_b        (hz_fwd_b)
    );

    assign stall = ld_use | br_ex | br_mem;

    // Bypass selects are captured every RUN cycle so the frozen ID
    // instruction keeps its sources while the MDU owns EX.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_RUN;
            to_cnt     <= 10'd0;
            stall_cnt  <= '0;
            err        <= 1'b0;
            hold_fwd_a <= FWD_RF;
            hold_fwd_b <= FWD_RF;
        end else begin
            state  <= state_nxt;
            to_cnt <= to_cnt_nxt;
            if (count_stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (state_nxt == ST_ERR)
                err <= 1'b1;
            if (state == ST_RUN) begin
                hold_fwd_a <= hz_fwd_a;
                hold_fwd_b <= hz_fwd_b;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        to_cnt_nxt  = to_cnt;
        pc_wr       = 1'b1;
        ifid_wr     = 1'b1;
        idex_wr     = 1'b1;
        exmem_wr    = 1'b1;
        memwb_wr    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        pcsel_en    = 1'b0;
        fwd_a       = FWD_RF;
        fwd_b       = FWD_RF;

        unique case (state)
            ST_RUN: begin
                fwd_a      = hz_fwd_a;
                fwd_b      = hz_fwd_b;
                to_cnt_nxt = 10'd0;
                if (stall) begin
                    pc_wr      = 1'b0;
                    ifid_wr    = 1'b0;
                    idex_flush = 1'b1;
                end else if (id_pcsel) begin
                    pcsel_en   = 1'b1;
                    ifid_flush = 1'b1;
                end
                if (ex_mdu_start)
                    state_nxt = ST_MDU_WAIT;
            end
            ST_MDU_WAIT: begin
                fwd_a = hold_fwd_a;
                fwd_b = hold_fwd_b;
                if (mdu_done) begin
                    state_nxt  = ST_RUN;
                    to_cnt_nxt = 10'd0;
                end else begin
                    pc_wr       = 1'b0;
                    ifid_wr     = 1'b0;
                    idex_wr     = 1'b0;
                    exmem_flush = 1'b1;
                    if (to_cnt == TO_LAST)
                        state_nxt = ST_ERR;
                    else
                        to_cnt_nxt = to_cnt + 10'd1;
                end
            end
            ST_ERR: begin
                pc_wr    = 1'b0;
                ifid_wr  = 1'b0;
                idex_wr  = 1'b0;
                exmem_wr = 1'b0;
                memwb_wr = 1'b0;
            end
            default: state_nxt = ST_RUN;
        endcase

        count_stall = (state != ST_ERR) && !pc_wr;

        // Reset forces a fully frozen, flushed pipe regardless of state.
        if (!rst) begin
            pc_wr       = 1'b0;
            ifid_wr     = 1'b0;
            idex_wr     = 1'b0;
            exmem_wr    = 1'b0;
            memwb_wr    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            pcsel_en    = 1'b0;
            fwd_a       = FWD_RF;
            fwd_b       = FWD_RF;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed pipeline scenarios with
// literal expectations, then randomized traffic against a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int TO = 8;
    localparam int CW = 4;
    localparam int SAT = 15;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [4:0] id_rs, id_rt, ex_rd, mem_rd, wb_rd;
    logic id_use_rs, id_use_rt, id_is_branch, id_pcsel;
    logic ex_regw, mem_regw, wb_regw, ex_memr, mem_memr, ex_mdu_start, mdu_done;
    logic pc_wr, ifid_wr, idex_wr, exmem_wr, memwb_wr;
    logic ifid_flush, idex_flush, exmem_flush, pcsel_en, err;
    logic [1:0] fwd_a, fwd_b;
    logic [CW-1:0] stall_cnt;

    pipe_hazard_ctrl #(.MDU_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_is_branch(id_is_branch), .id_pcsel(id_pcsel),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_regw(ex_regw), .mem_regw(mem_regw), .wb_regw(wb_regw),
        .ex_memr(ex_memr), .mem_memr(mem_memr),
        .ex_mdu_start(ex_mdu_start), .mdu_done(mdu_done),
        .pc_wr(pc_wr), .ifid_wr(ifid_wr), .idex_wr(idex_wr), .exmem_wr(exmem_wr),
        .memwb_wr(memwb_wr), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .pcsel_en(pcsel_en),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: mode 0 = running, 1 = waiting on MDU, 2 = error.
    int m_mode, m_wait, m_stalls;
    bit m_err;
    logic [1:0] m_hold_a, m_hold_b;

    logic e_pc, e_ifid, e_idex, e_exmem, e_memwb;
    logic e_ifid_fl, e_idex_fl, e_exmem_fl, e_pcsel;
    logic [1:0] e_fa, e_fb;

    function automatic bit hit(input logic [4:0] src, input logic used,
                               input logic [4:0] dst, input logic w);
        return used && w && dst != 5'd0 && src == dst;
    endfunction

    function automatic logic [1:0] pick_fwd(input logic [4:0] src, input logic used);
        if (hit(src, used, mem_rd, mem_regw) && !mem_memr) return 2'b01;
        if (hit(src, used, wb_rd, wb_regw)) return 2'b10;
        return 2'b00;
    endfunction

    task check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task compute_expected;
        bit ex_hit, mem_hit, st;
        {e_pc, e_ifid, e_idex, e_exmem, e_memwb} = 5'b11111;
        {e_ifid_fl, e_idex_fl, e_exmem_fl, e_pcsel} = 4'b0000;
        e_fa = 2'b00;
        e_fb = 2'b00;
        if (!rst) begin
            {e_pc, e_ifid, e_idex, e_exmem, e_memwb} = 5'b00000;
            {e_ifid_fl, e_idex_fl, e_exmem_fl} = 3'b111;
        end else if (m_mode == 0) begin
            ex_hit  = hit(id_rs, id_use_rs, ex_rd, ex_regw) || hit(id_rt, id_use_rt, ex_rd, ex_regw);
            mem_hit = hit(id_rs, id_use_rs, mem_rd, mem_regw) || hit(id_rt, id_use_rt, mem_rd, mem_regw);
            st = (ex_hit && ex_memr) || (id_is_branch && ex_hit) || (id_is_branch && mem_hit && mem_memr);
            e_fa = pick_fwd(id_rs, id_use_rs);
            e_fb = pick_fwd(id_rt, id_use_rt);
            if (st) begin
                e_pc = 0; e_ifid = 0; e_idex_fl = 1;
            end else if (id_pcsel) begin
                e_pcsel = 1; e_ifid_fl = 1;
            end
        end else if (m_mode == 1) begin
            e_fa = m_hold_a;
            e_fb = m_hold_b;
            if (!mdu_done) begin
                e_pc = 0; e_ifid = 0; e_idex = 0; e_exmem_fl = 1;
            end
        end else begin
            {e_pc, e_ifid, e_idex, e_exmem, e_memwb} = 5'b00000;
        end
    endtask

    task checkOutput;
        compute_expected();
        check_val("pc_wr", pc_wr, e_pc);
        check_val("ifid_wr", ifid_wr, e_ifid);
        check_val("idex_wr", idex_wr, e_idex);
        check_val("exmem_wr", exmem_wr, e_exmem);
        check_val("memwb_wr", memwb_wr, e_memwb);
        check_val("ifid_flush", ifid_flush, e_ifid_fl);
        check_val("idex_flush", idex_flush, e_idex_fl);
        check_val("exmem_flush", exmem_flush, e_exmem_fl);
        check_val("pcsel_en", pcsel_en, e_pcsel);
        check_val("fwd_a", fwd_a, e_fa);
        check_val("fwd_b", fwd_b, e_fb);
        check_val("stall_cnt", stall_cnt, m_stalls);
        check_val("err", err, m_err);
    endtask

    task model_step;
        if (m_mode != 2 && !e_pc && m_stalls < SAT) m_stalls++;
        case (m_mode)
            0: begin
                m_hold_a = e_fa;
                m_hold_b = e_fb;
                if (ex_mdu_start) begin m_mode = 1; m_wait = 0; end
            end
            1: begin
                if (mdu_done) m_mode = 0;
                else if (m_wait == TO - 1) begin m_mode = 2; m_err = 1; end
                else m_wait++;
            end
            default: ;
        endcase
    endtask

    task model_clear;
        m_mode = 0; m_wait = 0; m_stalls = 0; m_err = 0;
        m_hold_a = 2'b00; m_hold_b = 2'b00;
    endtask

    task set_idle;
        {id_rs, id_rt, ex_rd, mem_rd, wb_rd} = '0;
        {id_use_rs, id_use_rt, id_is_branch, id_pcsel} = '0;
        {ex_regw, mem_regw, wb_regw, ex_memr, mem_memr, ex_mdu_start, mdu_done} = '0;
    endtask

    task do_cycle;
        checkOutput();
        model_step();
        @(posedge clk);
        #1;
    endtask

    // Reset is asserted mid-cycle to exercise the asynchronous clear.
    task do_reset;
        rst = 1'b0;
        model_clear();
        #2;
        check_val("rst_err", err, 0);
        check_val("rst_exmem_flush", exmem_flush, 1);
        checkOutput();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task applyStimulus;
        id_rs = 5'($urandom_range(0, 3));
        id_rt = 5'($urandom_range(0, 3));
        ex_rd = 5'($urandom_range(0, 3));
        mem_rd = 5'($urandom_range(0, 3));
        wb_rd = 5'($urandom_range(0, 3));
        id_use_rs = 1'($urandom_range(0, 1));
        id_use_rt = 1'($urandom_range(0, 1));
        id_is_branch = 1'($urandom_range(0, 1));
        id_pcsel = 1'($urandom_range(0, 1));
        ex_regw = 1'($urandom_range(0, 1));
        mem_regw = 1'($urandom_range(0, 1));
        wb_regw = 1'($urandom_range(0, 1));
        ex_memr = 1'($urandom_range(0, 1));
        mem_memr = 1'($urandom_range(0, 1));
        ex_mdu_start = ($urandom_range(0, 9) == 0);
        mdu_done = ($urandom_range(0, 5) == 0);
    endtask

    initial begin
        int err_cycles;
        set_idle();
        model_clear();
        #1;
        do_reset();

        // lw $2 in EX, add reads $2 in ID
        set_idle(); ex_rd = 2; ex_regw = 1; ex_memr = 1; id_rs = 2; id_use_rs = 1;
        #2;
        check_val("lu_pc_wr", pc_wr, 0);
        check_val("lu_idex_flush", idex_flush, 1);
        check_val("lu_cnt0", stall_cnt, 0);
        do_cycle();
        set_idle(); mem_rd = 2; mem_regw = 1; mem_memr = 1; id_rs = 2; id_use_rs = 1;
        #2;
        check_val("lu_after_pc_wr", pc_wr, 1);
        check_val("lu_cnt1", stall_cnt, 1);
        do_cycle();

        // $0 producer never stalls
        set_idle(); ex_regw = 1; ex_memr = 1; id_use_rs = 1;
        #2;
        check_val("x0_pc_wr", pc_wr, 1);
        do_cycle();

        // MEM beats WB for bypass; WB used once MEM stops writing
        set_idle(); mem_rd = 4; mem_regw = 1; wb_rd = 4; wb_regw = 1; id_rs = 4; id_use_rs = 1;
        #2;
        check_val("fwd_mem", fwd_a, 2'b01);
        do_cycle();
        mem_regw = 0;
        #2;
        check_val("fwd_wb", fwd_a, 2'b10);
        do_cycle();

        // beq $3 behind lw $3: two bubbles then taken
        set_idle(); id_is_branch = 1; id_pcsel = 1; id_rs = 3; id_use_rs = 1;
        ex_rd = 3; ex_regw = 1; ex_memr = 1;
        #2;
        check_val("br1_pcsel_en", pcsel_en, 0);
        check_val("br1_pc_wr", pc_wr, 0);
        do_cycle();
        ex_regw = 0; ex_memr = 0; mem_rd = 3; mem_regw = 1; mem_memr = 1;
        #2;
        check_val("br2_pc_wr", pc_wr, 0);
        do_cycle();
        mem_regw = 0; mem_memr = 0; wb_rd = 3; wb_regw = 1;
        #2;
        check_val("br3_pcsel_en", pcsel_en, 1);
        check_val("br3_ifid_flush", ifid_flush, 1);
        do_cycle();

        // MDU operation with five wait cycles
        do_reset();
        set_idle(); ex_mdu_start = 1;
        #2;
        do_cycle();
        set_idle();
        for (int i = 0; i < 5; i++) begin
            #2;
            check_val("mdu_pc_wr", pc_wr, 0);
            check_val("mdu_exmem_flush", exmem_flush, 1);
            do_cycle();
        end
        mdu_done = 1;
        #2;
        check_val("mdu_done_pc_wr", pc_wr, 1);
        check_val("mdu_done_exmem_flush", exmem_flush, 0);
        do_cycle();
        mdu_done = 0;
        #2;
        check_val("mdu_stalls", stall_cnt, 5);
        do_cycle();

        // MDU timeout into the sticky error state
        do_reset();
        set_idle(); ex_mdu_start = 1;
        #2;
        do_cycle();
        set_idle();
        for (int i = 0; i < TO; i++) begin
            #2;
            check_val("to_err_low", err, 0);
            do_cycle();
        end
        #2;
        check_val("to_err", err, 1);
        check_val("to_memwb_wr", memwb_wr, 0);
        check_val("to_exmem_flush", exmem_flush, 0);
        check_val("to_stalls", stall_cnt, TO);
        do_cycle();
        do_reset();

        // Counter saturation under a permanent load-use
        set_idle(); ex_rd = 1; ex_regw = 1; ex_memr = 1; id_rt = 1; id_use_rt = 1;
        for (int i = 0; i < SAT + 2; i++) begin
            #2;
            do_cycle();
        end
        #2;
        check_val("sat_cnt", stall_cnt, SAT);
        do_cycle();

        // Randomized traffic with periodic resets
        do_reset();
        err_cycles = 0;
        for (int i = 0; i < 3000; i++) begin
            applyStimulus();
            #2;
            do_cycle();
            if (m_mode == 2) err_cycles++;
            if (err_cycles > 3 || $urandom_range(0, 299) == 0) begin
                err_cycles = 0;
                do_reset();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
